// File: rtl/stream_line_arbiter.sv
// stream_line_arbiter
// Shares one downstream pixel-stream consumer between two valid/ready
// sources. A whole line of LINE_LEN beats is granted to one source at a
// time. Lines alternate round-robin when both sources have data. Each
// output beat is tagged with its source id, end-of-line and end-of-frame.
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous reset, active low
//   in0_valid/ready     source 0 handshake, in0_data source 0 beat
//   in1_valid/ready     source 1 handshake, in1_data source 1 beat
//   out_valid/ready     downstream handshake, out_data forwarded beat
//   out_src             source id of the current beat / current grant
//   out_eol             current beat is the last beat of its line
//   out_eof             current beat is the last beat of its source's frame
//   busy                a line burst is currently granted
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | arbitration bubble; no transfer; pick next source by rr_ptr
// S_BURST | granted source passed straight through until its line ends

module stream_line_arbiter #(
    parameter int DATA_WIDTH      = 8,
    parameter int LINE_LEN        = 640,
    parameter int LINES_PER_FRAME = 480
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in0_valid,
    output logic                  in0_ready,
    input  logic [DATA_WIDTH-1:0] in0_data,
    input  logic                  in1_valid,
    output logic                  in1_ready,
    input  logic [DATA_WIDTH-1:0] in1_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_src,
    output logic                  out_eol,
    output logic                  out_eof,
    output logic                  busy
);

    localparam int BW = $clog2(LINE_LEN);
    localparam int LW = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_LEN - 1);
    localparam logic [LW-1:0] LAST_LINE = LW'(LINES_PER_FRAME - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t          r_state, w_state_nxt;
    logic            r_grant, w_grant_nxt;
    logic            r_rr_ptr, w_rr_nxt;
    logic [BW-1:0]   r_beat_cnt, w_beat_nxt;
    logic [LW-1:0]   r_line_cnt0, r_line_cnt1;
    logic [LW-1:0]   w_line0_nxt, w_line1_nxt;
    logic [LW-1:0]   w_line_cur, w_line_inc;
    logic            w_busy, w_sel_valid, w_xfer;
    logic            w_rr_valid, w_other_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_grant     <= 1'b0;
            r_rr_ptr    <= 1'b0;
            r_beat_cnt  <= '0;
            r_line_cnt0 <= '0;
            r_line_cnt1 <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_beat_cnt  <= w_beat_nxt;
            r_line_cnt0 <= w_line0_nxt;
            r_line_cnt1 <= w_line1_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_rr_nxt    = r_rr_ptr;
        w_beat_nxt  = r_beat_cnt;
        w_line0_nxt = r_line_cnt0;
        w_line1_nxt = r_line_cnt1;

        w_busy        = (r_state == S_BURST);
        w_sel_valid   = r_grant ? in1_valid : in0_valid;
        w_rr_valid    = r_rr_ptr ? in1_valid : in0_valid;
        w_other_valid = r_rr_ptr ? in0_valid : in1_valid;
        w_line_cur    = r_grant ? r_line_cnt1 : r_line_cnt0;
        w_line_inc    = (w_line_cur == LAST_LINE) ? '0 : w_line_cur + 1'b1;

        // Zero-latency pass-through of the granted source; the ungranted
        // source never sees ready, so it simply waits for its turn.
        out_valid = w_busy & w_sel_valid;
        in0_ready = w_busy & ~r_grant & out_ready;
        in1_ready = w_busy &  r_grant & out_ready;
        out_data  = r_grant ? in1_data : in0_data;
        out_src   = r_grant;
        busy      = w_busy;

        // Tags depend only on beat position, so they are visible even
        // while the granted source is stalled.
        out_eol = w_busy & (r_beat_cnt == LAST_BEAT);
        out_eof = out_eol & (w_line_cur == LAST_LINE);

        w_xfer = out_valid & out_ready;

        case (r_state)
            S_IDLE: begin
                if (w_rr_valid) begin
                    w_grant_nxt = r_rr_ptr;
                    w_state_nxt = S_BURST;
                end else if (w_other_valid) begin
                    w_grant_nxt = ~r_rr_ptr;
                    w_state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                if (w_xfer) begin
                    if (out_eol) begin
                        w_beat_nxt  = '0;
                        w_rr_nxt    = ~r_grant;
                        w_state_nxt = S_IDLE;
                        if (r_grant) w_line1_nxt = w_line_inc;
                        else         w_line0_nxt = w_line_inc;
                    end else begin
                        w_beat_nxt = r_beat_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_stream_line_arbiter.sv
// Bench for stream_line_arbiter with LINE_LEN=4, LINES_PER_FRAME=2.
// A cycle-level reference model follows the arbitration rules with plain
// integers; scenario tasks add their own per-transfer expectations.

module tb_stream_line_arbiter;

    localparam int DW  = 8;
    localparam int L   = 4;
    localparam int LPF = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in0_valid, in1_valid, in0_ready, in1_ready;
    logic [DW-1:0] in0_data, in1_data, out_data;
    logic          out_valid, out_ready, out_src, out_eol, out_eof, busy;

    stream_line_arbiter #(.DATA_WIDTH(DW), .LINE_LEN(L), .LINES_PER_FRAME(LPF)) dut (
        .clk(clk), .reset(reset),
        .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_data(in0_data),
        .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_src(out_src), .out_eol(out_eol), .out_eof(out_eof), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests, fails;

    // source drivers: mode 0 always valid, 1 never, 2 random
    bit v[2];
    int idx[2];
    int mode[2];
    int drop_at[2];
    int drop_left[2];
    bit acc[2];

    // reference model
    bit m_busy, m_g, m_rr;
    int m_beat;
    int m_lines[2];

    // per-cycle snapshot
    logic [14:0] s_exp, s_act;
    bit          s_xfer, s_src, s_eol, s_eof;
    logic [7:0]  s_data;

    function automatic bit pick(int s);
        if (mode[s] == 0) return 1'b1;
        if (mode[s] == 1) return 1'b0;
        return ($urandom_range(0, 3) != 0);
    endfunction

    task automatic src_drive();
        in0_valid = v[0];
        in1_valid = v[1];
        in0_data  = 8'(8'h10 + idx[0]);
        in1_data  = 8'(8'h20 + idx[1]);
    endtask

    task automatic model_reset();
        m_busy = 0; m_g = 0; m_rr = 0; m_beat = 0;
        m_lines[0] = 0; m_lines[1] = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) v[s] = pick(s);
        src_drive();
        #2 reset = 1'b1;
    endtask

    // One clock: snapshot expected/actual at the falling edge, step the model,
    // then advance the sources after the rising edge.
    task automatic cycle();
        bit ev, er0, er1, eeol, eeof;
        logic [7:0] ed;
        @(negedge clk);
        ev   = m_busy && v[m_g];
        er0  = m_busy && !m_g && out_ready;
        er1  = m_busy && m_g && out_ready;
        eeol = m_busy && (m_beat == L - 1);
        eeof = eeol && (m_lines[m_g] == LPF - 1);
        ed   = m_busy ? (m_g ? in1_data : in0_data) : 8'h00;
        s_exp = {ev, er0, er1, m_g, eeol, eeof, m_busy, ed};
        s_act = {out_valid, in0_ready, in1_ready, out_src, out_eol, out_eof, busy,
                 (m_busy ? out_data : 8'h00)};
        s_xfer = out_valid && out_ready;
        s_src  = out_src;
        s_eol  = out_eol;
        s_eof  = out_eof;
        s_data = out_data;
        acc[0] = v[0] && in0_ready;
        acc[1] = v[1] && in1_ready;
        if (!m_busy) begin
            if (v[m_rr]) begin
                m_g = m_rr; m_busy = 1;
            end else if (v[!m_rr]) begin
                m_g = !m_rr; m_busy = 1;
            end
        end else if (ev && out_ready) begin
            if (m_beat == L - 1) begin
                m_beat = 0;
                m_lines[m_g] = (m_lines[m_g] + 1) % LPF;
                m_rr = !m_g;
                m_busy = 0;
            end else begin
                m_beat++;
            end
        end
        @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            if (acc[s]) idx[s]++;
            if (acc[s] || !v[s]) begin
                if (idx[s] == drop_at[s] && drop_left[s] > 0) begin
                    v[s] = 0;
                    drop_left[s]--;
                end else begin
                    v[s] = pick(s);
                end
            end
        end
        src_drive();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        v[0] = 1; v[1] = 1;
        out_ready = 1'b1;
        src_drive();
        repeat (2) @(posedge clk);
        #2;
        tests++;
        if ({out_valid, in0_ready, in1_ready, out_eol, out_eof, busy, out_src} !== 7'b0) begin
            fails++;
            $display("FAIL reset_outputs act=%b exp=0000000",
                     {out_valid, in0_ready, in1_ready, out_eol, out_eof, busy, out_src});
        end
    endtask

    task automatic test_alternation();
        int k;
        bit e_src, e_eol;
        mode[0] = 0; mode[1] = 0; out_ready = 1'b1;
        do_reset();
        k = 0;
        for (int c = 0; c < 20; c++) begin
            cycle();
            tests++;
            if (s_act !== s_exp) begin
                fails++;
                $display("FAIL alt_cycle c=%0d act=%h exp=%h", c, s_act, s_exp);
            end
            if (s_xfer) begin
                e_src = ((k / L) % 2) == 1;
                e_eol = (k % L) == L - 1;
                tests++;
                if ({s_src, s_eol} !== {e_src, e_eol}) begin
                    fails++;
                    $display("FAIL alt_src_eol k=%0d act=%b%b exp=%b%b", k, s_src, s_eol, e_src, e_eol);
                end
                k++;
            end
        end
        tests++;
        if (k != 16) begin
            fails++;
            $display("FAIL alt_count act=%0d exp=16", k);
        end
    endtask

    task automatic test_single_source();
        int k;
        logic [15:0] eofs;
        mode[0] = 1; mode[1] = 0; out_ready = 1'b1;
        do_reset();
        k = 0; eofs = '0;
        for (int c = 0; c < 20; c++) begin
            cycle();
            tests++;
            if (s_act !== s_exp) begin
                fails++;
                $display("FAIL single_cycle c=%0d act=%h exp=%h", c, s_act, s_exp);
            end
            if (s_xfer && k < 16) begin
                eofs[k] = s_eof;
                tests++;
                if (s_src !== 1'b1) begin
                    fails++;
                    $display("FAIL single_src k=%0d act=%b exp=1", k, s_src);
                end
                k++;
            end
        end
        tests++;
        if (eofs !== 16'h8080) begin
            fails++;
            $display("FAIL single_eof act=%h exp=8080", eofs);
        end
    endtask

    task automatic test_valid_drop();
        int k;
        bit e_src;
        mode[0] = 0; mode[1] = 0; out_ready = 1'b1;
        drop_at[0] = idx[0] + 2;
        drop_left[0] = 3;
        do_reset();
        k = 0;
        for (int c = 0; c < 25; c++) begin
            cycle();
            tests++;
            if (s_act !== s_exp) begin
                fails++;
                $display("FAIL drop_cycle c=%0d act=%h exp=%h", c, s_act, s_exp);
            end
            if (s_xfer) begin
                if (k < 8) begin
                    e_src = (k >= 4);
                    tests++;
                    if (s_src !== e_src) begin
                        fails++;
                        $display("FAIL drop_src k=%0d act=%b exp=%b", k, s_src, e_src);
                    end
                end
                k++;
            end
        end
        drop_at[0] = -1;
        drop_left[0] = 0;
    endtask

    task automatic test_backpressure();
        int seen[2];
        bit pat[4];
        logic [7:0] ed;
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
        mode[0] = 0; mode[1] = 0; out_ready = 1'b1;
        do_reset();
        seen[0] = idx[0]; seen[1] = idx[1];
        for (int c = 0; c < 40; c++) begin
            out_ready = pat[c % 4];
            cycle();
            tests++;
            if (s_act !== s_exp) begin
                fails++;
                $display("FAIL bp_cycle c=%0d act=%h exp=%h", c, s_act, s_exp);
            end
            if (s_xfer) begin
                ed = s_src ? 8'(8'h20 + seen[1]) : 8'(8'h10 + seen[0]);
                tests++;
                if (s_data !== ed) begin
                    fails++;
                    $display("FAIL bp_scoreboard c=%0d act=%h exp=%h", c, s_data, ed);
                end
                seen[s_src]++;
            end
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset_mid_burst();
        int n, k;
        bit first_src;
        logic [15:0] eofs;
        mode[0] = 1; mode[1] = 0; out_ready = 1'b1;
        do_reset();
        n = 0;
        for (int c = 0; c < 30 && n < 6; c++) begin
            cycle();
            tests++;
            if (s_act !== s_exp) begin
                fails++;
                $display("FAIL rst_pre_cycle c=%0d act=%h exp=%h", c, s_act, s_exp);
            end
            if (s_xfer) n++;
        end
        tests++;
        if (n != 6) begin
            fails++;
            $display("FAIL rst_setup act=%0d exp=6", n);
        end
        tests++;
        if ({out_valid, in1_ready} !== 2'b11) begin
            fails++;
            $display("FAIL rst_pre_valid act=%b exp=11", {out_valid, in1_ready});
        end
        reset = 1'b0;
        #1;
        tests++;
        if ({out_valid, in1_ready, busy, out_eol} !== 4'b0) begin
            fails++;
            $display("FAIL rst_async_drop act=%b exp=0000", {out_valid, in1_ready, busy, out_eol});
        end
        model_reset();
        mode[0] = 0;
        @(posedge clk);
        #1;
        v[0] = 1; v[1] = 1;
        src_drive();
        #2 reset = 1'b1;
        k = 0; eofs = '0; first_src = 1'b1;
        for (int c = 0; c < 20; c++) begin
            cycle();
            tests++;
            if (s_act !== s_exp) begin
                fails++;
                $display("FAIL rst_post_cycle c=%0d act=%h exp=%h", c, s_act, s_exp);
            end
            if (s_xfer && k < 16) begin
                if (k == 0) first_src = s_src;
                eofs[k] = s_eof;
                k++;
            end
        end
        tests++;
        if (first_src !== 1'b0) begin
            fails++;
            $display("FAIL rst_first_grant act=%b exp=0", first_src);
        end
        tests++;
        if (eofs !== 16'h8800) begin
            fails++;
            $display("FAIL rst_eof_pattern act=%h exp=8800", eofs);
        end
    endtask

    task automatic test_eof();
        int pos[2];
        int ln[2];
        bit e_eof, e_eol;
        mode[0] = 0; mode[1] = 0; out_ready = 1'b1;
        do_reset();
        pos[0] = 0; pos[1] = 0; ln[0] = 0; ln[1] = 0;
        for (int c = 0; c < 40; c++) begin
            cycle();
            tests++;
            if (s_act !== s_exp) begin
                fails++;
                $display("FAIL eof_cycle c=%0d act=%h exp=%h", c, s_act, s_exp);
            end
            if (s_xfer) begin
                e_eol = (pos[s_src] == L - 1);
                e_eof = e_eol && (ln[s_src] % LPF == LPF - 1);
                tests++;
                if ({s_eol, s_eof} !== {e_eol, e_eof}) begin
                    fails++;
                    $display("FAIL eof_tag c=%0d src=%0d act=%b%b exp=%b%b",
                             c, s_src, s_eol, s_eof, e_eol, e_eof);
                end
                if (pos[s_src] == L - 1) begin
                    pos[s_src] = 0;
                    ln[s_src]++;
                end else begin
                    pos[s_src]++;
                end
            end
        end
    endtask

    task automatic test_random();
        int seen[2];
        logic [7:0] ed;
        mode[0] = 2; mode[1] = 2; out_ready = 1'b1;
        do_reset();
        seen[0] = idx[0]; seen[1] = idx[1];
        for (int c = 0; c < 400; c++) begin
            out_ready = ($urandom_range(0, 2) != 0);
            cycle();
            tests++;
            if (s_act !== s_exp) begin
                fails++;
                $display("FAIL rand_cycle c=%0d act=%h exp=%h", c, s_act, s_exp);
            end
            if (s_xfer) begin
                ed = s_src ? 8'(8'h20 + seen[1]) : 8'(8'h10 + seen[0]);
                tests++;
                if (s_data !== ed) begin
                    fails++;
                    $display("FAIL rand_scoreboard c=%0d act=%h exp=%h", c, s_data, ed);
                end
                seen[s_src]++;
            end
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        for (int s = 0; s < 2; s++) begin
            v[s] = 0; idx[s] = 0; mode[s] = 0;
            drop_at[s] = -1; drop_left[s] = 0; acc[s] = 0;
        end
        out_ready = 1'b1;
        model_reset();
        src_drive();
        test_reset();
        test_alternation();
        test_single_source();
        test_valid_drop();
        test_backpressure();
        test_reset_mid_burst();
        test_eof();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stream_line_arbiter.md
Name: stream_line_arbiter

Overview:
Shares one downstream pixel-stream consumer (block-matching engine input) between two valid/ready pixel sources, e.g. left and right camera streams. Grants whole lines of LINE_LEN beats, alternating sources round-robin, and never interleaves beats within a line. Tags each output beat with source id, end-of-line and end-of-frame so the consumer can demultiplex. Sits between the stream sources and the matcher's input FIFO.

Parameters:
DATA_WIDTH, 8, width of a data beat in bits
LINE_LEN, 640, beats per line; legal range >= 2
LINES_PER_FRAME, 480, lines per frame per source; legal range >= 1

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
in0_valid  in  1  source 0 beat valid
in0_ready  out  1  source 0 beat accepted when in0_valid & in0_ready
in0_data  in  DATA_WIDTH  source 0 beat
in1_valid  in  1  source 1 beat valid
in1_ready  out  1  source 1 beat accepted when in1_valid & in1_ready
in1_data  in  DATA_WIDTH  source 1 beat
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts beat
out_data  out  DATA_WIDTH  output beat
out_src  out  1  source id of current beat / grant
out_eol  out  1  current beat is last of its line
out_eof  out  1  current beat is last of its source's frame
busy  out  1  high while a line burst is granted

Behaviour:
- State: FSM {IDLE, BURST}, grant (1b), rr_ptr (1b), beat_cnt ($clog2(LINE_LEN) bits), line_cnt0/line_cnt1 ($clog2(LINES_PER_FRAME) bits, min 1 bit).
- Reset (reset==0, async): state IDLE, grant 0, rr_ptr 0, beat_cnt 0, both line_cnt 0. Outputs while in IDLE: out_valid 0, in0_ready 0, in1_ready 0, out_eol 0, out_eof 0, busy 0; out_src = grant (0 after reset); out_data don't-care.
- IDLE: if source rr_ptr has valid, grant <= rr_ptr; else if other source valid, grant <= other; else stay IDLE. On grant, next state BURST. One-cycle arbitration bubble; no beat transferred in IDLE.
- BURST: out_valid = in{grant}_valid; in{grant}_ready = out_ready; ungranted source ready = 0; out_data = in{grant}_data; out_src = grant; busy 1. Pass-through combinational, zero latency, no buffering.
- Transfer = out_valid & out_ready. Each transfer: beat_cnt += 1.
- out_eol = busy & (beat_cnt == LINE_LEN-1). out_eof = out_eol & (line_cnt{grant} == LINES_PER_FRAME-1). Both combinational, qualified by beat position, independent of out_valid.
- Last-beat transfer (out_eol & transfer): beat_cnt <= 0; line_cnt{grant} increments, wraps to 0 after LINES_PER_FRAME-1; rr_ptr <= ~grant; state <= IDLE.
- Grant is held for the full line: grant source dropping valid mid-line stalls output (out_valid 0), no re-arbitration; other source waits regardless.
- out_ready low: beat held, counters frozen; source must hold data (valid/ready rule).
- Only one source ever valid: it is granted on every arbitration (consecutive lines, one bubble each).
- Both valid at arbitration: rr_ptr wins; strict alternation per line thereafter.
- Line counters independent per source; eof of one source does not affect the other.
- Reset asserted mid-burst: line aborted immediately, all counters cleared; partial line not resumed.

Test Plan:
(LINE_LEN=4, LINES_PER_FRAME=2, DATA_WIDTH=8 for all.)
1. Reset release, both sources always valid (src0 data 0x10.., src1 0x20..), out_ready=1 -> out_src sequence 0,0,0,0,1,1,1,1,0..., one out_valid=0 bubble between lines, out_eol on beats 3,7,11...
2. Only src1 valid, out_ready=1 -> 4 lines of src1, out_eof high on 4th beat of lines 2 and 4; in0_ready stays 0.
3. Src0 granted, drop in0_valid for 3 cycles after beat 1, src1 valid throughout -> output stalls, in1_ready 0, line completes with src0 beats 2,3 before src1 granted.
4. out_ready toggled 1,0,0,1 mid-line -> out_data/out_eol stable while stalled, beat_cnt frozen, no beat duplicated or dropped (scoreboard vs source data).
5. Reset pulsed low after beat 2 of a src1 line -> in1_ready and out_valid drop in same cycle (async), after release src0 granted first, line_cnt restarted (out_eof on src0's 2nd line).
6. Both sources valid, src0 frame = 2 lines -> out_eof asserted only on beat 3 of src0 line 2 and src1 line 2, never on line 1.
